// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed scan controller for a 4-digit seven-segment
//               display. Each digit slot is CLK_DIV cycles long and begins with
//               BLANK_CYC cycles of all-anodes-off. The display word is double
//               buffered (pending -> shadow) so digits only change at frame
//               boundaries.
//               Optional feature macro: LEADING_ZERO_BLANK_EN
//               (blanks leading zero digits 3..1 when their dp bit is clear).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] disp,
    input  logic        disp_ld,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int               c_cnt_w     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_blank = c_cnt_w'(BLANK_CYC);

    localparam logic [3:0] c_an_off  = (AN_ACTIVE_LOW  != 0) ? 4'hF  : 4'h0;
    localparam logic [6:0] c_seg_off = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       c_dp_off  = (SEG_ACTIVE_LOW != 0);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_scan = 1'b1;

    // Shadow/pending are packed as {disp[15:0], dp_mask[3:0]}
    logic [0:0]         state_q,   state_d;
    logic [c_cnt_w-1:0] cnt_q,     cnt_d;
    logic [1:0]         digit_q,   digit_d;
    logic [19:0]        pending_q, pending_d;
    logic [19:0]        shadow_q,  shadow_d;
    logic [3:0]         an_q,      an_d;
    logic [6:0]         seg_q,     seg_d;
    logic               dp_q,      dp_d;

    logic               w_scan_run;
    logic               w_frame_end;
    logic               w_drive;
    logic               w_lz_blank;
    logic [3:0]         w_nib;
    logic [3:0]         w_an_onehot;

    // Active-high hex-to-segment decode, {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign w_scan_run  = (state_q == c_st_scan) && en;
    assign w_frame_end = w_scan_run && (cnt_q == c_cnt_last) && (digit_q == 2'd3);
    assign frame_done  = w_frame_end;

    // State, counters, buffers and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= c_st_idle;
            cnt_q     <= '0;
            digit_q   <= 2'd0;
            pending_q <= 20'h0;
            shadow_q  <= 20'h0;
            an_q      <= c_an_off;
            seg_q     <= c_seg_off;
            dp_q      <= c_dp_off;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    // Next-state: enable starts scanning, dropping it returns to idle at once
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (en)  state_d = c_st_scan;
            c_st_scan: if (!en) state_d = c_st_idle;
            default:            state_d = c_st_idle;
        endcase
    end

    // Slot/digit sequencing and double-buffer transfers
    always_comb begin
        cnt_d     = cnt_q;
        digit_d   = digit_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;

        if (disp_ld) begin
            pending_d = {disp, dp_mask};
        end

        if (state_q == c_st_idle) begin
            cnt_d   = '0;
            digit_d = 2'd0;
            if (en) begin
                shadow_d = pending_q;
            end
        end else if (!en) begin
            cnt_d   = '0;
            digit_d = 2'd0;
        end else begin
            if (cnt_q == c_cnt_last) begin
                cnt_d   = '0;
                digit_d = digit_q + 2'd1;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
            // A strobe on the boundary cycle bypasses pending so it is not lost a frame
            if (w_frame_end) begin
                shadow_d = disp_ld ? {disp, dp_mask} : pending_q;
            end
        end
    end

    // Output pattern for the current counter value, registered one cycle later
    always_comb begin
        w_nib       = shadow_q[4 + 4*digit_q +: 4];
        w_an_onehot = 4'b0001 << digit_q;
        w_drive     = w_scan_run && (cnt_q >= c_cnt_blank);
`ifdef LEADING_ZERO_BLANK_EN
        case (digit_q)
            2'd3:    w_lz_blank = (shadow_q[19:16] == 4'h0)  && !shadow_q[3];
            2'd2:    w_lz_blank = (shadow_q[19:12] == 8'h0)  && !shadow_q[2];
            2'd1:    w_lz_blank = (shadow_q[19:8]  == 12'h0) && !shadow_q[1];
            default: w_lz_blank = 1'b0;
        endcase
`else
        w_lz_blank = 1'b0;
`endif
        an_d  = c_an_off;
        seg_d = c_seg_off;
        dp_d  = c_dp_off;
        if (w_drive && !w_lz_blank) begin
            an_d  = (AN_ACTIVE_LOW  != 0) ? ~w_an_onehot        : w_an_onehot;
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~hex_decode(w_nib)  : hex_decode(w_nib);
            dp_d  = (SEG_ACTIVE_LOW != 0) ? ~shadow_q[digit_q]  : shadow_q[digit_q];
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display on the RGB LED driver board. It takes the 16-bit packed display word (4 hex nibbles, digit 0 = bits [3:0] = rightmost) and drives one digit at a time. Each digit gets a programmable dwell, with an inter-digit blanking gap to prevent ghosting. The display word is double-buffered so digits only change at frame boundaries, which prevents tearing.

Parameters:
CLK_DIV, 50000, clock cycles per digit slot (blank + drive); must be >= 2
BLANK_CYC, 500, cycles at start of each slot with all anodes off; must satisfy 1 <= BLANK_CYC < CLK_DIV
SEG_ACTIVE_LOW, 1, 1 = segments/dp driven low-true; 0 = high-true
AN_ACTIVE_LOW, 1, 1 = anode enables low-true; 0 = high-true

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; 0 forces display dark
disp  input  16  packed display word, nibble n -> digit n
disp_ld  input  1  single-cycle strobe; capture disp into pending register
dp_mask  input  4  decimal point per digit, bit n -> digit n (sampled with disp on disp_ld)
an  output  4  digit anode enables, bit n -> digit n
seg  output  7  segments {g,f,e,d,c,b,a}
dp  output  1  decimal point segment
frame_done  output  1  one-cycle pulse at end of each full 4-digit frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs inactive (an=4'hF, seg=7'h7F, dp=1 with default params); frame_done=0; pending/shadow = 0; digit index = 0; slot counter = 0.
- Registers: pending {disp, dp_mask} loaded on any cycle with disp_ld=1. Shadow loaded from pending at the frame boundary. If disp_ld coincides with the boundary, shadow takes the incoming disp/dp_mask directly.
- States:
  - IDLE: outputs off. Exits to SCAN with digit=0, cnt=0 on the first edge with en=1. Shadow loads from pending on that edge.
  - SCAN: cnt runs 0..CLK_DIV-1 per slot.
- Within a slot:
  - cnt < BLANK_CYC: all anodes off, seg off.
  - cnt >= BLANK_CYC: an[digit] active, seg = decode(shadow nibble[digit]), dp = dp_mask[digit].
- Slot and frame sequencing:
  - At cnt = CLK_DIV-1: cnt -> 0 and digit increments mod 4.
  - When digit = 3 wraps to 0: frame_done = 1 for that cycle and shadow reloads.
- Output timing: an/seg/dp are registered; the pattern for counter value k appears one cycle after the counter holds k. frame_done is asserted in the same cycle in which cnt = CLK_DIV-1 and digit = 3.
- Frame period: 4 * CLK_DIV cycles.
- en deasserted in any SCAN cycle: next edge -> IDLE, outputs off, cnt/digit cleared, no frame_done. Pending is retained.
- Decode (active-high, hex 0..F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. Output is inverted when SEG_ACTIVE_LOW=1. The an polarity follows AN_ACTIVE_LOW.
- Never more than one anode active. All anodes are off for at least BLANK_CYC cycles between digits.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: during digits 3, 2 and 1, the anode stays off if that nibble and all higher nibbles of shadow are 0 and that digit's dp_mask bit is 0. Digit 0 is always driven. Slot timing and frame_done are unchanged.
- Undefined: all four digits are always driven.

Test Plan:
- Reset: rst_n=0 mid-drive -> an=4'hF, seg=7'h7F, dp=1, frame_done=0 immediately (async); after release with en=1, scanning restarts at digit 0.
- Basic scan (CLK_DIV=8, BLANK_CYC=2):
  - Stimulus: disp_ld with disp=16'h1234, then en=1.
  - Required: per 8-cycle slot, 2 cycles an=4'hF then 6 cycles an=1110/1101/1011/0111 in order.
  - Required seg values: digit0 7'h19 ('4'), digit1 7'h30 ('3'), digit2 7'h24 ('2'), digit3 7'h79 ('1').
  - Required: frame_done pulses every 32 cycles.
- Tear-free update: disp_ld 16'hABCD during digit 1 slot of a 16'h1234 frame -> digits 2 and 3 still show '2' and '1'; the next frame shows digit0 7'h21 ('d'), digit3 7'h08 ('A').
- Boundary coincidence: disp_ld 16'h0F00 on the frame_done cycle -> the very next frame shows digit2 = 7'h0E ('F').
- Enable drop: en=0 at cnt=5 of digit 2 -> outputs off next cycle, no frame_done. Then en=1 -> blank then digit 0 (an=1110), old shadow intact.
- LEADING_ZERO_BLANK_EN defined:
  - disp=16'h0050, dp_mask=0 -> digits 3 and 2 keep an off; digit1 shows 7'h12 ('5'), digit0 shows 7'h40 ('0').
  - disp=16'h0000 -> only digit 0 is lit.
  - dp_mask=4'b1000 -> digit 3 is lit with '0' and dp=0.
